// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and elaboration helpers for the systolic array sequencer.
package systolic_pkg;

    // Default array dimension (rows = columns).
    localparam int N_DEF = 4;

    // Sequencer phases.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Width of the phase counter t: it must hold the last FEED value
    // (k_len_max + N - 2) and the last FLUSH value (N - 2 + PE_LAT).
    function automatic int t_width_f(input int n, input int k_w, input int pe_lat);
        int feed_max;
        int flush_max;
        int top;
        int w;
        feed_max  = ((32'sd1 <<< k_w) - 32'sd1) + n - 32'sd2;
        flush_max = n - 32'sd2 + pe_lat;
        top       = (feed_max > flush_max) ? feed_max : flush_max;
        w         = $clog2(top + 32'sd1);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host command, operand-buffer, PE-array and drain handshake bundle.
// master = host/array side, slave = the sequencer.
interface systolic_seq_ctrl_if #(
    parameter int N   = 4,
    parameter int K_W = 8
);
    localparam int RW = $clog2(N);

    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy;
    logic           done;
    logic           pe_clr;
    logic           rd_en;
    logic [K_W-1:0] rd_k;
    logic [N-1:0]   row_en;
    logic [N-1:0]   col_en;
    logic           res_valid;
    logic [RW-1:0]  res_row;
    logic           res_ready;

    modport master (
        output start, k_len, res_ready,
        input  busy, done, pe_clr, rd_en, rd_k, row_en, col_en, res_valid, res_row
    );

    modport slave (
        input  start, k_len, res_ready,
        output busy, done, pe_clr, rd_en, rd_k, row_en, col_en, res_valid, res_row
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic MAC array: clear, skewed operand feed,
// pipeline flush, then a row-by-row drain under valid/ready.
// Outputs are registered from the next-state decode, so each output is a
// pure function of (state, t, latched k_len, drain row) with no input path.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int K_W    = 8,
    parameter int PE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.slave  bus
);

    localparam int T_W = t_width_f(N, K_W, PE_LAT);
    localparam int RW  = $clog2(N);

    localparam logic [T_W-1:0] T_ZERO     = T_W'(0);
    localparam logic [T_W-1:0] T_ONE      = T_W'(1);
    localparam logic [T_W-1:0] FLUSH_LAST = T_W'(N - 2 + PE_LAT);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(N - 1);

    state_e         state_r;
    state_e         state_nxt_s;
    logic [T_W-1:0] t_r;
    logic [T_W-1:0] t_nxt_s;
    logic [K_W-1:0] klen_r;
    logic [K_W-1:0] klen_nxt_s;
    logic [RW-1:0]  row_r;
    logic [RW-1:0]  row_nxt_s;

    logic [T_W-1:0] feed_last_s;
    logic [T_W-1:0] klen_nxt_ext_s;
    logic           feed_nxt_s;
    logic           rd_en_nxt_s;
    logic [N-1:0]   skew_nxt_s;

    logic           busy_r;
    logic           done_r;
    logic           pe_clr_r;
    logic           rd_en_r;
    logic [K_W-1:0] rd_k_r;
    logic [N-1:0]   row_en_r;
    logic [N-1:0]   col_en_r;
    logic           res_valid_r;
    logic [RW-1:0]  res_row_r;

    // Zero-extended compares keep k_len = 2^K_W-1 from wrapping t.
    assign feed_last_s    = T_W'(klen_r) + T_W'(N - 2);
    assign klen_nxt_ext_s = T_W'(klen_nxt_s);
    assign feed_nxt_s     = (state_nxt_s == FEED);
    assign rd_en_nxt_s    = feed_nxt_s && (t_nxt_s < klen_nxt_ext_s);

    // Skew decode: lane i is live for k_len beats starting at t = i.
    // Written as (t - i) < k_len so k_len + i never has to fit in T_W.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign skew_nxt_s[i] = feed_nxt_s
                               && (t_nxt_s >= T_W'(i))
                               && ((t_nxt_s - T_W'(i)) < klen_nxt_ext_s);
    end

    // Next-state, counter, latched length and drain-row computation.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        klen_nxt_s  = klen_r;
        row_nxt_s   = row_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = CLEAR;
                    klen_nxt_s  = bus.k_len;
                    t_nxt_s     = T_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                t_nxt_s   = T_ZERO;
                row_nxt_s = RW'(0);
                if (klen_r == K_W'(0)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FEED;
                end
            end
            FEED: begin
                if (t_r == feed_last_s) begin
                    state_nxt_s = FLUSH;
                    t_nxt_s     = T_ZERO;
                end else begin
                    t_nxt_s = t_r + T_ONE;
                end
            end
            FLUSH: begin
                if (t_r == FLUSH_LAST) begin
                    state_nxt_s = DRAIN;
                    t_nxt_s     = T_ZERO;
                    row_nxt_s   = RW'(0);
                end else begin
                    t_nxt_s = t_r + T_ONE;
                end
            end
            DRAIN: begin
                if (bus.res_ready) begin
                    if (row_r == ROW_LAST) begin
                        state_nxt_s = DONE;
                    end else begin
                        row_nxt_s = row_r + RW'(1);
                    end
                end else begin
                    row_nxt_s = row_r;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                t_nxt_s     = T_ZERO;
            end
        endcase
    end

    // State register plus registered Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            t_r         <= T_ZERO;
            klen_r      <= K_W'(0);
            row_r       <= RW'(0);
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pe_clr_r    <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_k_r      <= K_W'(0);
            row_en_r    <= {N{1'b0}};
            col_en_r    <= {N{1'b0}};
            res_valid_r <= 1'b0;
            res_row_r   <= RW'(0);
        end else begin
            state_r     <= state_nxt_s;
            t_r         <= t_nxt_s;
            klen_r      <= klen_nxt_s;
            row_r       <= row_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == DONE);
            pe_clr_r    <= (state_nxt_s == CLEAR);
            rd_en_r     <= rd_en_nxt_s;
            rd_k_r      <= rd_en_nxt_s ? t_nxt_s[K_W-1:0] : K_W'(0);
            row_en_r    <= skew_nxt_s;
            col_en_r    <= skew_nxt_s;
            res_valid_r <= (state_nxt_s == DRAIN);
            res_row_r   <= (state_nxt_s == DRAIN) ? row_nxt_s : RW'(0);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pe_clr    = pe_clr_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.rd_k      = rd_k_r;
    assign bus.row_en    = row_en_r;
    assign bus.col_en    = col_en_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_row   = res_row_r;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: per-cycle expected output vectors are
// generated from the phase lengths of each job and checked every cycle.
module tb_systolic_seq_ctrl;

    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int PE_LAT = 3;
    localparam int RW     = 2;

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           pe_clr;
        logic           rd_en;
        logic [K_W-1:0] rd_k;
        logic [N-1:0]   row_en;
        logic [N-1:0]   col_en;
        logic           res_valid;
        logic [RW-1:0]  res_row;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(N), .K_W(K_W)) bus ();

    systolic_seq_ctrl #(.N(N), .K_W(K_W), .PE_LAT(PE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt;

    function automatic vec_t observe();
        return {bus.busy, bus.done, bus.pe_clr, bus.rd_en, bus.rd_k,
                bus.row_en, bus.col_en, bus.res_valid, bus.res_row};
    endfunction

    task automatic check_vec(input string tag, input int c, input vec_t e);
        vec_t o;
        o = observe();
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expected trace for cycles 1.. of a job (cycle 0 = accepting edge),
    // ending with one idle cycle; a reset at end of cycle rc truncates it.
    task automatic build(input int k, input int s0, input int s1, input int rc);
        vec_t v;
        int   c;
        int   row;
        bit   stalled;
        exp_q.delete();
        v = '0; v.busy = 1'b1; v.pe_clr = 1'b1;
        exp_q.push_back(v);
        c = 2;
        if (k > 0) begin
            for (int f = 0; f <= k + N - 2; f++) begin
                v = '0;
                v.busy  = 1'b1;
                v.rd_en = (f < k);
                v.rd_k  = v.rd_en ? K_W'(f) : '0;
                for (int i = 0; i < N; i++) v.row_en[i] = (f >= i) && (f < k + i);
                v.col_en = v.row_en;
                exp_q.push_back(v);
                c++;
            end
            for (int f = 0; f < N - 1 + PE_LAT; f++) begin
                v = '0; v.busy = 1'b1;
                exp_q.push_back(v);
                c++;
            end
        end
        row = 0;
        while (1'b1) begin
            v = '0; v.busy = 1'b1; v.res_valid = 1'b1; v.res_row = RW'(row);
            exp_q.push_back(v);
            stalled = (s0 > 0) && (c >= s0) && (c <= s1);
            c++;
            if (!stalled) begin
                if (row == N - 1) break;
                row++;
            end
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
        exp_q.push_back('0);
        if (rc > 0) begin
            while (exp_q.size() > rc) void'(exp_q.pop_back());
            exp_q.push_back('0);
        end
    endtask

    // One job: start at cycle 0, stall res_ready over [s0,s1], pulse start
    // at cycles p0/p1 (should be ignored), optional reset at end of cycle rc.
    task automatic run_job(input string tag, input int k, input int s0, input int s1,
                           input int p0, input int p1, input int rc);
        int   c;
        int   frm;
        vec_t e;
        build(k, s0, s1, rc);
        busy_cnt      = 0;
        bus.start     = 1'b1;
        bus.k_len     = K_W'(k);
        bus.res_ready = 1'b1;
        c = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_vec(tag, c, e);
            if (bus.busy) busy_cnt++;
            bus.start     = (c == p0) || (c == p1);
            bus.k_len     = bus.start ? K_W'(7) : K_W'(k);
            bus.res_ready = !((s0 > 0) && (c >= s0) && (c <= s1));
            rst           = (rc > 0) && (c == rc);
            c++;
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        if (rc == 0) begin
            if (k == 0) frm = 2 + N;
            else        frm = 1 + (k + N - 1) + (N - 1 + PE_LAT) + N + 1;
            if (s0 > 0) frm += s1 - s0 + 1;
            check_int({tag, "_cycles"}, busy_cnt, frm);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("reset", 0, '0);
        rst = 1'b0;

        run_job("basic", 4, 0, 0, 0, 0, 0);
        run_job("stall", 4, 16, 17, 0, 0, 0);
        run_job("k0", 0, 0, 0, 0, 0, 0);
        run_job("ignore_start", 4, 0, 0, 4, 19, 0);
        run_job("rst_flush", 4, 0, 0, 0, 0, 10);
        run_job("k1", 1, 0, 0, 0, 0, 0);
        run_job("k255", 255, 0, 0, 0, 0, 0);

        repeat (3) begin
            @(negedge clk);
            check_vec("idle_end", 0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
